// File: rtl/modsub_pipe.sv
// Streaming modular subtractor C = (A - B) mod q on a two-stage elastic pipeline with a pass-through tag.
// Latency 2 edges (accept -> S1 -> S2); full valid/ready backpressure, holds 2 beats, in_ready depends combinationally on out_ready.
module modsub_pipe #(
  parameter int LOGQ  = 64,
  parameter int LOGQH = 47,
  parameter int TAGW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOGQ-1:0]  A,
  input  logic [LOGQ-1:0]  B,
  input  logic [LOGQH-1:0] qH,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOGQ-1:0]  C,
  output logic [TAGW-1:0]  out_tag
);

  localparam int W = LOGQ - LOGQH;
  localparam logic [LOGQ-1:0] ONE = LOGQ'(1);

  // Only the low LOGQ bits of Dq are ever selected, so its carry bit is not kept.
  typedef struct packed {
    logic [LOGQ:0]   d;
    logic [LOGQ-1:0] dq;
    logic [TAGW-1:0] tag;
  } s1_t;

  logic [LOGQ-1:0] qh_ext;
  logic [LOGQ-1:0] q_val;

  assign qh_ext = LOGQ'(qH);

  generate
    if (W > 0) begin : g_ntt_mod
      assign q_val = (qh_ext << W) | ONE;
    end else begin : g_plain_mod
      assign q_val = qh_ext;
    end
  endgenerate

  logic            s1_v;
  logic            s2_v;
  s1_t             s1_nxt;
  s1_t             s1_q;
  logic [LOGQ-1:0] c_nxt;
  logic [LOGQ-1:0] c_q;
  logic [TAGW-1:0] tag_q;
  logic            s2_free;
  logic            s1_move;
  logic            accept;

  assign s2_free  = !s2_v || out_ready;
  assign s1_move  = s1_v && s2_free;
  assign in_ready = !rst && (!s1_v || s2_free);
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_nxt     = '0;
    s1_nxt.d   = {1'b0, A} - {1'b0, B};
    s1_nxt.dq  = s1_nxt.d[LOGQ-1:0] + q_val;
    s1_nxt.tag = in_tag;
  end

  // A set top bit of D is the borrow: fold q back in.
  assign c_nxt = s1_q.d[LOGQ] ? s1_q.dq : s1_q.d[LOGQ-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v  <= 1'b0;
      s2_v  <= 1'b0;
      s1_q  <= '0;
      c_q   <= '0;
      tag_q <= '0;
    end else begin
      if (accept) begin
        s1_v <= 1'b1;
        s1_q <= s1_nxt;
      end else if (s1_move) begin
        s1_v <= 1'b0;
      end

      if (s1_move) begin
        s2_v  <= 1'b1;
        c_q   <= c_nxt;
        tag_q <= s1_q.tag;
      end else if (out_ready) begin
        s2_v <= 1'b0;
      end
    end
  end

  assign out_valid = s2_v && !rst;
  assign C         = c_q;
  assign out_tag   = tag_q;

endmodule
